// File: rtl/execute_add.sv
// Execute stage of the add-only pipeline: forwarded operands, add/sub,
// and a single-entry valid/ready result register toward writeback.
module execute_add #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rs,
  input  logic [4:0]             in_rt,
  input  logic [4:0]             write_dest,
  input  logic [5:0]             in_funct,
  input  logic [WIDTH-1:0]       read_reg_1,
  input  logic [WIDTH-1:0]       read_reg_2,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_dest,
  input  logic [WIDTH-1:0]       wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic [4:0]             result_dest,
  output logic                   result_wen,
  output logic                   overflow,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;

  logic                   r_valid;
  logic [WIDTH-1:0]       r_result;
  logic [4:0]             r_dest;
  logic                   r_wen;
  logic                   r_ovf;
  logic                   r_ill;
  logic [COUNT_WIDTH-1:0] r_count;

  logic                   w_accept;
  logic                   w_self_ok;
  logic [WIDTH-1:0]       w_a;
  logic [WIDTH-1:0]       w_b;
  logic [WIDTH-1:0]       w_sum;
  logic [WIDTH-1:0]       w_diff;
  logic [WIDTH-1:0]       w_res;
  logic                   w_ovf;
  logic                   w_ill;
  logic                   w_wen;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Own result only counts as a source if it will actually be committed.
  assign w_self_ok = r_valid && r_wen;

  always_comb begin
    w_a = read_reg_1;
    if (w_self_ok && r_dest == in_rs && in_rs != 5'd0)
      w_a = r_result;
    else if (wb_valid && wb_dest == in_rs && wb_dest != 5'd0)
      w_a = wb_data;
  end

  always_comb begin
    w_b = read_reg_2;
    if (w_self_ok && r_dest == in_rt && in_rt != 5'd0)
      w_b = r_result;
    else if (wb_valid && wb_dest == in_rt && wb_dest != 5'd0)
      w_b = wb_data;
  end

  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    unique case (1'b1)
      (in_funct == F_ADD): begin
        w_res = w_sum;
        w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      (in_funct == F_ADDU): w_res = w_sum;
      (in_funct == F_SUB): begin
        w_res = w_diff;
        w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      (in_funct == F_SUBU): w_res = w_diff;
      default: w_ill = 1'b1;
    endcase
  end

  assign w_wen = !w_ill && !w_ovf && (write_dest != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_dest   <= '0;
      r_wen    <= 1'b0;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_result <= w_res;
      r_dest   <= write_dest;
      r_wen    <= w_wen;
      r_ovf    <= w_ovf;
      r_ill    <= w_ill;
      r_count  <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign result      = r_result;
  assign result_dest = r_dest;
  assign result_wen  = r_wen;
  assign overflow    = r_ovf;
  assign illegal     = r_ill;
  assign instr_count = r_count;

endmodule

// File: doc/execute_add.md
Name: execute_add

Overview:
- Execute stage of the add-only pipeline. Sits directly downstream of decode.
- Takes decoded operands, destination register and funct; performs add/addu/sub/subu with one-cycle latency.
- Forwards its own last result and the writeback result to cover read-after-write hazards.
- Hands the result to writeback through a single-entry valid/ready output register.

Parameters:
WIDTH, 32, datapath width of operands and result
COUNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  decode presents a valid instruction
in_ready  output  1  stage can accept this cycle
in_rs  input  5  source register index 1
in_rt  input  5  source register index 2
write_dest  input  5  destination register index (rd) from decode
in_funct  input  6  funct field
read_reg_1  input  WIDTH  operand A as read by decode
read_reg_2  input  WIDTH  operand B as read by decode
wb_valid  input  1  writeback stage writing this cycle
wb_dest  input  5  writeback destination index
wb_data  input  WIDTH  writeback data
out_valid  output  1  result register holds a valid entry
out_ready  input  1  writeback consumes the entry this cycle
result  output  WIDTH  computed value
result_dest  output  5  destination index for result
result_wen  output  1  writeback must commit result
overflow  output  1  signed overflow on trapping op
illegal  output  1  unsupported funct
instr_count  output  COUNT_WIDTH  instructions accepted since reset

Behaviour:
- Reset (rst high at clk edge): out_valid, result, result_dest, result_wen, overflow, illegal and instr_count all go to 0. Reset overrides any in-flight or stalled entry; that entry is lost.
- in_ready = !out_valid || out_ready. This is combinational and has no dependence on in_valid.
- accept = in_valid && in_ready.
- On accept at edge N: output register loads and out_valid = 1 from edge N onward (latency 1). instr_count increments, wrapping modulo 2^COUNT_WIDTH.
- No accept, and out_valid && out_ready: out_valid -> 0; other outputs hold their values.
- No accept, and out_valid && !out_ready: all outputs hold (stall).
- Simultaneous consume and accept: the new entry replaces the old one; there is no bubble.
- Operand A forwarding, first match wins:
  (1) out_valid && result_wen && result_dest == in_rs && in_rs != 0 -> result;
  (2) wb_valid && wb_dest == in_rs && wb_dest != 0 -> wb_data;
  (3) otherwise read_reg_1.
- Operand B: same selection using in_rt and read_reg_2.
- Funct decode:
  - 0x20 add: A+B, signed overflow checked.
  - 0x21 addu: A+B, no check.
  - 0x22 sub: A-B, signed overflow checked.
  - 0x23 subu: A-B, no check.
  - Arithmetic is modulo 2^WIDTH; carry is discarded.
- Signed overflow (add: operand signs equal and result sign differs; sub: operand signs differ and result sign differs from A) gives overflow = 1 and result_wen = 0. The wrapped result is still presented.
- Any other funct gives illegal = 1, result = 0, result_wen = 0, overflow = 0.
- write_dest == 0 gives result_wen = 0; result is still computed.
- result_wen = 1 only for a legal funct, no overflow, and write_dest != 0.
- overflow and illegal describe the current output entry only; they reload on every accept.

Test Plan:
- Basic add: A=5, B=7, funct 0x20, rd=3, out_ready=1 -> one cycle later out_valid=1, result=12, result_dest=3, result_wen=1, instr_count=1.
- Overflow: A=0x7FFFFFFF, B=1, funct 0x20 -> result=0x80000000, overflow=1, result_wen=0. Same operands with 0x21 -> overflow=0, result_wen=1. A=0x80000000, B=1, funct 0x22 -> overflow=1.
- Back-to-back forwarding: instr1 rd=4 gives 12. Next cycle instr2 has rs=4, read_reg_1=0x99 (stale), B=1, funct 0x21 -> result=13. With rs=0 and a matching dest -> read_reg_1 is used.
- Priority: wb_valid=1, wb_dest=4, wb_data=100 while out entry has dest 4, value 12 -> A=12. With out_valid=0 -> A=100. With result_wen=0 (overflowed entry) -> A=100.
- Stall/backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, instr_count unchanged. Raise out_ready -> same-cycle accept of the pending instruction, no bubble; out_valid drops only when in_valid=0.
- Reset and illegal: assert rst during a stall -> next edge all outputs 0 and the entry is discarded. After reset, funct 0x24 -> illegal=1, result=0, result_wen=0, instr_count=1.
